// File: rtl/foxtrot_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : foxtrot_wb_pkg
//  Description : Shared writeback types: result packet layout and slot map
//                used by the writeback arbiter and by fu_if consumers.
//  Revision    : 1.0 - initial release
// ============================================================================
package foxtrot_wb_pkg;

    // Result slots per packet; slot 2 always carries the NZCV flags result.
    localparam int NUM_RESULT_SLOTS = 3;
    localparam int FLAGS_SLOT       = 2;

    // Default field widths of the shared packet type.
    localparam int WB_INST_ID_W = 7;
    localparam int WB_PRN_W     = 7;
    localparam int WB_DATA_W    = 64;

    typedef struct packed {
        logic [WB_INST_ID_W-1:0]                          inst_id;
        logic [NUM_RESULT_SLOTS-1:0][WB_PRN_W-1:0]        prn;
        logic [NUM_RESULT_SLOTS-1:0][WB_DATA_W-1:0]       data;
        logic [NUM_RESULT_SLOTS-1:0]                      data_valid;
    } wb_pkt_t;

endpackage : foxtrot_wb_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Small per-FU result FIFO. Pointers wrap naturally, count is
//                one bit wider than the pointers. Flush empties it at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import foxtrot_wb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type PKT_T = wb_pkt_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  PKT_T                     push_pkt,
    input  logic                     pop,
    output PKT_T                     head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    PKT_T            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    // Overflow/underflow protection: a push on full or a pop on empty is dropped.
    assign w_push = push && (r_count < CW'(DEPTH));
    assign w_pop  = pop && (r_count != '0);
    assign head   = r_mem[r_rd_ptr];
    assign count  = r_count;

    // Pointer and occupancy tracking; reset and flush both empty the FIFO.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_pkt;
    end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/fu_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fu_wb_arbiter
//  Description : Writeback arbiter. Buffers each FU's result in a FIFO and
//                grants one packet per cycle, round-robin, onto a registered
//                common data bus. Optional macro FU_WB_ARBITER_BYPASS_EN lets
//                an input whose FIFO is empty be granted in its arrival cycle
//                when no FIFO head is pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module fu_wb_arbiter
    import foxtrot_wb_pkg::*;
#(
    parameter int NUM_FU     = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int INST_ID_W  = 7,
    parameter int PRN_W      = 7,
    parameter int DATA_W     = 64
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   flush,
    input  logic [NUM_FU-1:0]                                      fu_in_valid,
    output logic [NUM_FU-1:0]                                      fu_in_ready,
    input  logic [NUM_FU-1:0][INST_ID_W-1:0]                       fu_in_inst_id,
    input  logic [NUM_FU-1:0][NUM_RESULT_SLOTS-1:0][PRN_W-1:0]     fu_in_prn,
    input  logic [NUM_FU-1:0][NUM_RESULT_SLOTS-1:0][DATA_W-1:0]    fu_in_data,
    input  logic [NUM_FU-1:0][NUM_RESULT_SLOTS-1:0]                fu_in_data_valid,
    output logic                                                   cdb_valid,
    output logic [$clog2(NUM_FU)-1:0]                              cdb_src,
    output logic [INST_ID_W-1:0]                                   cdb_inst_id,
    output logic [NUM_RESULT_SLOTS-1:0][PRN_W-1:0]                 cdb_prn,
    output logic [NUM_RESULT_SLOTS-1:0][DATA_W-1:0]                cdb_data,
    output logic [NUM_RESULT_SLOTS-1:0]                            cdb_data_valid
);

    localparam int SRC_W = $clog2(NUM_FU);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Packet layout matching wb_pkt_t but sized by this instance's parameters.
    typedef struct packed {
        logic [INST_ID_W-1:0]                        inst_id;
        logic [NUM_RESULT_SLOTS-1:0][PRN_W-1:0]      prn;
        logic [NUM_RESULT_SLOTS-1:0][DATA_W-1:0]     data;
        logic [NUM_RESULT_SLOTS-1:0]                 data_valid;
    } pkt_t;

    // k-th position of the round-robin scan starting at base, modulo NUM_FU.
    function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_FU) s = s - NUM_FU;
        return SRC_W'(s);
    endfunction

    pkt_t               w_in_pkt [NUM_FU];
    pkt_t               w_head   [NUM_FU];
    logic [CNT_W-1:0]   w_count  [NUM_FU];
    logic [NUM_FU-1:0]  w_head_cand;
    logic [NUM_FU-1:0]  w_push;
    logic [NUM_FU-1:0]  w_pop;
`ifdef FU_WB_ARBITER_BYPASS_EN
    logic [NUM_FU-1:0]  w_byp_cand;
`endif
    logic               w_gnt_found;
    logic               w_gnt_byp;
    logic [SRC_W-1:0]   w_gnt_idx;
    pkt_t               w_sel_pkt;
    logic [SRC_W-1:0]   r_rr_ptr;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        assign w_in_pkt[i]    = {fu_in_inst_id[i], fu_in_prn[i], fu_in_data[i], fu_in_data_valid[i]};
        // Ready depends on occupancy only, so a full FIFO stays not-ready even
        // when it is popped in the same cycle.
        assign fu_in_ready[i] = (w_count[i] < CNT_W'(FIFO_DEPTH));
        assign w_head_cand[i] = (w_count[i] != '0);
        // A bypassed packet goes straight to the CDB and must not also be stored.
        assign w_push[i]      = fu_in_valid[i] && fu_in_ready[i]
                                && !(w_gnt_byp && (w_gnt_idx == SRC_W'(i)));
        assign w_pop[i]       = w_gnt_found && !w_gnt_byp && (w_gnt_idx == SRC_W'(i));
`ifdef FU_WB_ARBITER_BYPASS_EN
        assign w_byp_cand[i]  = !w_head_cand[i] && fu_in_valid[i];
`endif

        wb_fifo #(
            .DEPTH (FIFO_DEPTH),
            .PKT_T (pkt_t)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .push     (w_push[i]),
            .push_pkt (w_in_pkt[i]),
            .pop      (w_pop[i]),
            .head     (w_head[i]),
            .count    (w_count[i])
        );
    end

    // Round-robin grant: FIFO heads first, then (optionally) bypass inputs.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_byp   = 1'b0;
        w_gnt_idx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!w_gnt_found && w_head_cand[rr_idx(r_rr_ptr, k)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = rr_idx(r_rr_ptr, k);
            end
        end
`ifdef FU_WB_ARBITER_BYPASS_EN
        for (int k = 0; k < NUM_FU; k++) begin
            if (!w_gnt_found && w_byp_cand[rr_idx(r_rr_ptr, k)]) begin
                w_gnt_found = 1'b1;
                w_gnt_byp   = 1'b1;
                w_gnt_idx   = rr_idx(r_rr_ptr, k);
            end
        end
`endif
    end

    assign w_sel_pkt = w_gnt_byp ? w_in_pkt[w_gnt_idx] : w_head[w_gnt_idx];

    // CDB register and round-robin pointer; flush drops the in-flight grant
    // but keeps the pointer so fairness survives a mispredict.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid      <= 1'b0;
            cdb_src        <= '0;
            cdb_inst_id    <= '0;
            cdb_prn        <= '0;
            cdb_data       <= '0;
            cdb_data_valid <= '0;
            r_rr_ptr       <= '0;
        end else if (flush) begin
            cdb_valid      <= 1'b0;
        end else if (w_gnt_found) begin
            cdb_valid      <= 1'b1;
            cdb_src        <= w_gnt_idx;
            cdb_inst_id    <= w_sel_pkt.inst_id;
            cdb_prn        <= w_sel_pkt.prn;
            cdb_data       <= w_sel_pkt.data;
            cdb_data_valid <= w_sel_pkt.data_valid;
            r_rr_ptr       <= (w_gnt_idx == SRC_W'(NUM_FU - 1)) ? '0 : w_gnt_idx + 1'b1;
        end else begin
            cdb_valid      <= 1'b0;
        end
    end

endmodule : fu_wb_arbiter
`default_nettype wire

// File: tb/tb_fu_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fu_wb_arbiter
//  Description : Self-checking bench for fu_wb_arbiter with a per-FU
//                scoreboard of accepted packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fu_wb_arbiter;

    localparam int NUM_FU = 4;
    localparam int DEPTH  = 2;
    localparam int IW     = 7;
    localparam int PW     = 7;
    localparam int DW     = 64;
    localparam int NS     = 3;
`ifdef FU_WB_ARBITER_BYPASS_EN
    localparam int LAT    = 1;
`else
    localparam int LAT    = 2;
`endif
    localparam int FLUSH_ID = 127;

    typedef struct packed {
        logic [IW-1:0]          inst_id;
        logic [NS-1:0][PW-1:0]  prn;
        logic [NS-1:0][DW-1:0]  data;
        logic [NS-1:0]          dv;
    } pkt_t;

    logic                              clk;
    logic                              rst;
    logic                              flush;
    logic [NUM_FU-1:0]                 fu_in_valid;
    logic [NUM_FU-1:0]                 fu_in_ready;
    logic [NUM_FU-1:0][IW-1:0]         fu_in_inst_id;
    logic [NUM_FU-1:0][NS-1:0][PW-1:0] fu_in_prn;
    logic [NUM_FU-1:0][NS-1:0][DW-1:0] fu_in_data;
    logic [NUM_FU-1:0][NS-1:0]         fu_in_data_valid;
    logic                              cdb_valid;
    logic [1:0]                        cdb_src;
    logic [IW-1:0]                     cdb_inst_id;
    logic [NS-1:0][PW-1:0]             cdb_prn;
    logic [NS-1:0][DW-1:0]             cdb_data;
    logic [NS-1:0]                     cdb_data_valid;

    fu_wb_arbiter #(
        .NUM_FU(NUM_FU), .FIFO_DEPTH(DEPTH), .INST_ID_W(IW), .PRN_W(PW), .DATA_W(DW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .fu_in_valid      (fu_in_valid),
        .fu_in_ready      (fu_in_ready),
        .fu_in_inst_id    (fu_in_inst_id),
        .fu_in_prn        (fu_in_prn),
        .fu_in_data       (fu_in_data),
        .fu_in_data_valid (fu_in_data_valid),
        .cdb_valid        (cdb_valid),
        .cdb_src          (cdb_src),
        .cdb_inst_id      (cdb_inst_id),
        .cdb_prn          (cdb_prn),
        .cdb_data         (cdb_data),
        .cdb_data_valid   (cdb_data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                checks = 0;
    int                errors = 0;
    pkt_t              exp_q [NUM_FU][$];
    pkt_t              cur   [NUM_FU];
    int                occ   [NUM_FU];
    int                bcast_cnt [NUM_FU];
    int                last_src = NUM_FU - 1;
    logic [NUM_FU-1:0] acc;
    logic              seen_flush_id = 1'b0;
    int                next_id = 1;
    pkt_t              mon_got;
    pkt_t              mon_exp;

    function automatic pkt_t make_pkt(input int id);
        pkt_t p;
        p.inst_id = IW'(id);
        for (int s = 0; s < NS; s++) begin
            p.prn[s]  = PW'(id * 3 + s);
            p.data[s] = {32'(id), 32'hC0DE_0000 + 32'(s)};
        end
        p.dv = NS'(id % 8);
        return p;
    endfunction

    task automatic set_in(input int fu, input pkt_t p);
        fu_in_valid[fu]      = 1'b1;
        fu_in_inst_id[fu]    = p.inst_id;
        fu_in_prn[fu]        = p.prn;
        fu_in_data[fu]       = p.data;
        fu_in_data_valid[fu] = p.dv;
        cur[fu]              = p;
    endtask

    task automatic clear_bench();
        for (int i = 0; i < NUM_FU; i++) begin
            exp_q[i].delete();
            occ[i] = 0;
        end
    endtask

    // One clock: record accepted packets, advance to just after the next falling edge.
    task automatic cycle();
        for (int i = 0; i < NUM_FU; i++) begin
            acc[i] = fu_in_valid[i] && fu_in_ready[i] && !flush;
            if (acc[i]) exp_q[i].push_back(cur[i]);
        end
        @(negedge clk);
        #1;
        for (int i = 0; i < NUM_FU; i++) begin
            if (acc[i]) occ[i]++;
            if (cdb_valid && int'(cdb_src) == i) occ[i]--;
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        flush       = 1'b0;
        fu_in_valid = '0;
        @(posedge clk);
        #1;
        clear_bench();
        last_src = NUM_FU - 1;
        rst      = 1'b0;
        @(negedge clk);
        #1;
    endtask

    // Scoreboard: every broadcast must be the oldest accepted packet of its FU.
    always @(negedge clk) begin
        if (cdb_valid === 1'b1) begin
            checks++;
            mon_got.inst_id = cdb_inst_id;
            mon_got.prn     = cdb_prn;
            mon_got.data    = cdb_data;
            mon_got.dv      = cdb_data_valid;
            if (cdb_inst_id == IW'(FLUSH_ID)) seen_flush_id = 1'b1;
            if (exp_q[cdb_src].size() == 0) begin
                errors++;
                $display("FAIL cdb_unexpected src %0d id %0d (no packet expected)", cdb_src, cdb_inst_id);
            end else begin
                mon_exp = exp_q[cdb_src].pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL cdb_payload src %0d got id %0d prn %h data %h dv %b want id %0d prn %h data %h dv %b",
                             cdb_src, mon_got.inst_id, mon_got.prn, mon_got.data, mon_got.dv,
                             mon_exp.inst_id, mon_exp.prn, mon_exp.data, mon_exp.dv);
                end
            end
            last_src = int'(cdb_src);
            bcast_cnt[cdb_src]++;
        end
    end

    task automatic check_drained(input string name);
        for (int i = 0; i < NUM_FU; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL %s_lost fu %0d got %0d undelivered want 0", name, i, exp_q[i].size());
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_cdb_valid got %b want 0", cdb_valid); end
        checks++;
        if (cdb_src !== 2'd0) begin errors++; $display("FAIL reset_cdb_src got %0d want 0", cdb_src); end
        checks++;
        if (cdb_inst_id !== '0 || cdb_prn !== '0) begin
            errors++; $display("FAIL reset_cdb_id_prn got %0d/%h want 0/0", cdb_inst_id, cdb_prn);
        end
        checks++;
        if (cdb_data !== '0 || cdb_data_valid !== '0) begin
            errors++; $display("FAIL reset_cdb_data got %h/%b want 0/0", cdb_data, cdb_data_valid);
        end
        checks++;
        if (fu_in_ready !== 4'b1111) begin errors++; $display("FAIL reset_ready got %b want 1111", fu_in_ready); end
    endtask

    task automatic test_single();
        pkt_t p;
        p         = '0;
        p.inst_id = 7'd5;
        p.prn[0]  = 7'd12;
        p.data[0] = 64'hDEAD_BEEF;
        p.dv      = 3'b001;
        set_in(2, p);
        cycle();
        fu_in_valid[2] = 1'b0;
        checks++;
        if (cdb_valid !== (LAT == 1)) begin
            errors++; $display("FAIL single_first_edge_valid got %b want %b", cdb_valid, (LAT == 1));
        end
        if (LAT == 2) cycle();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd2) begin
            errors++; $display("FAIL single_broadcast got valid %b src %0d want 1 src 2", cdb_valid, cdb_src);
        end
        checks++;
        if (cdb_inst_id !== 7'd5 || cdb_prn[0] !== 7'd12 || cdb_data[0] !== 64'hDEAD_BEEF || cdb_data_valid !== 3'b001) begin
            errors++; $display("FAIL single_payload got id %0d prn0 %0d data0 %h dv %b want 5 12 deadbeef 001",
                               cdb_inst_id, cdb_prn[0], cdb_data[0], cdb_data_valid);
        end
        cycle();
        checks++;
        if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_no_repeat got %b want 0", cdb_valid); end
        check_drained("single");
    endtask

    task automatic test_fairness();
        int                srcs[$];
        logic [NUM_FU-1:0] saw_low;
        saw_low = '0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (!fu_in_valid[i]) begin
                    set_in(i, make_pkt(next_id));
                    next_id++;
                end
                if (!fu_in_ready[i]) saw_low[i] = 1'b1;
                checks++;
                if (fu_in_ready[i] !== (occ[i] < DEPTH)) begin
                    errors++; $display("FAIL fair_ready fu %0d cyc %0d got %b want %b", i, c, fu_in_ready[i], (occ[i] < DEPTH));
                end
            end
            cycle();
            for (int i = 0; i < NUM_FU; i++) if (acc[i]) fu_in_valid[i] = 1'b0;
            if (cdb_valid) srcs.push_back(int'(cdb_src));
        end
        fu_in_valid = '0;
        for (int c = 0; c < 16; c++) begin
            cycle();
            if (cdb_valid) srcs.push_back(int'(cdb_src));
        end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (srcs.size() <= k) begin
                errors++; $display("FAIL fair_order grant %0d got none want src %0d", k, k % NUM_FU);
            end else if (srcs[k] != k % NUM_FU) begin
                errors++; $display("FAIL fair_order grant %0d got src %0d want %0d", k, srcs[k], k % NUM_FU);
            end
        end
        checks++;
        if (saw_low !== 4'b1111) begin errors++; $display("FAIL fair_ready_dropped got %b want 1111", saw_low); end
        check_drained("fair");
    endtask

    task automatic test_full_boundary();
        int   f1_acc;
        int   b1_before;
        logic saw_low;
        f1_acc    = 0;
        b1_before = 0;
        saw_low   = 1'b0;
        do_reset();
        for (int c = 0; c < 20 && f1_acc < 3; c++) begin
            if (!fu_in_valid[0]) begin set_in(0, make_pkt(next_id)); next_id++; end
            if (!fu_in_valid[1]) begin set_in(1, make_pkt(next_id)); next_id++; end
            checks++;
            if (fu_in_ready[1] !== (occ[1] < DEPTH)) begin
                errors++; $display("FAIL full_ready1 cyc %0d got %b want %b", c, fu_in_ready[1], (occ[1] < DEPTH));
            end
            if (f1_acc == 2 && !fu_in_ready[1]) saw_low = 1'b1;
            b1_before = bcast_cnt[1];
            cycle();
            if (acc[0]) fu_in_valid[0] = 1'b0;
            if (acc[1]) begin
                fu_in_valid[1] = 1'b0;
                f1_acc++;
                if (f1_acc == 3) begin
                    checks++;
                    if (b1_before < 1) begin
                        errors++; $display("FAIL full_third_early fu1 grants before accept got %0d want >=1", b1_before);
                    end
                end
            end
        end
        checks++;
        if (f1_acc != 3) begin errors++; $display("FAIL full_timeout fu1 accepts got %0d want 3", f1_acc); end
        checks++;
        if (saw_low !== (LAT == 2)) begin
            errors++; $display("FAIL full_ready_after_two got low-seen %b want %b", saw_low, (LAT == 2));
        end
        fu_in_valid = '0;
        for (int c = 0; c < 10; c++) cycle();
        check_drained("full");
    endtask

    task automatic test_flush();
        int   exp_rr;
        int   total;
        int   first_src;
        do_reset();
        for (int i = 0; i < NUM_FU; i++) begin set_in(i, make_pkt(next_id)); next_id++; end
        cycle();
        fu_in_valid = '0;
        for (int i = 0; i < 2; i++) begin set_in(i, make_pkt(next_id)); next_id++; end
        cycle();
        fu_in_valid = '0;
        total = 0;
        for (int i = 0; i < NUM_FU; i++) total += occ[i];
        checks++;
        if (total != ((LAT == 2) ? 5 : 4)) begin
            errors++; $display("FAIL flush_prefill got %0d buffered want %0d", total, (LAT == 2) ? 5 : 4);
        end
        exp_rr = (last_src + 1) % NUM_FU;
        set_in(3, make_pkt(FLUSH_ID));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        fu_in_valid = '0;
        clear_bench();
        @(negedge clk);
        #1;
        checks++;
        if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_cdb_valid got %b want 0", cdb_valid); end
        checks++;
        if (fu_in_ready !== 4'b1111) begin errors++; $display("FAIL flush_ready got %b want 1111", fu_in_ready); end
        for (int i = 0; i < NUM_FU; i++) begin set_in(i, make_pkt(next_id)); next_id++; end
        cycle();
        fu_in_valid = '0;
        first_src = -1;
        for (int c = 0; c < 5 && first_src < 0; c++) begin
            if (cdb_valid) first_src = int'(cdb_src);
            else cycle();
        end
        checks++;
        if (first_src != exp_rr) begin
            errors++; $display("FAIL flush_rr_kept first grant got %0d want %0d", first_src, exp_rr);
        end
        for (int c = 0; c < 8; c++) cycle();
        checks++;
        if (seen_flush_id !== 1'b0) begin errors++; $display("FAIL flush_pkt_broadcast got 1 want 0"); end
        check_drained("flush");
    endtask

    task automatic test_back_to_back();
        int base_cnt;
        do_reset();
        base_cnt = bcast_cnt[0];
        for (int c = 0; c < 10; c++) begin
            set_in(0, make_pkt(next_id));
            next_id++;
            checks++;
            if (fu_in_ready[0] !== 1'b1) begin errors++; $display("FAIL stream_ready cyc %0d got %b want 1", c, fu_in_ready[0]); end
            cycle();
            if (c >= LAT - 1) begin
                checks++;
                if (cdb_valid !== 1'b1 || cdb_src !== 2'd0) begin
                    errors++; $display("FAIL stream_bcast cyc %0d got valid %b src %0d want 1 src 0", c, cdb_valid, cdb_src);
                end
            end
        end
        fu_in_valid = '0;
        for (int c = 0; c < LAT + 2; c++) cycle();
        checks++;
        if (bcast_cnt[0] - base_cnt != 10) begin
            errors++; $display("FAIL stream_count got %0d want 10", bcast_cnt[0] - base_cnt);
        end
        check_drained("stream");
    endtask

    initial begin
        rst              = 1'b1;
        flush            = 1'b0;
        fu_in_valid      = '0;
        fu_in_inst_id    = '0;
        fu_in_prn        = '0;
        fu_in_data       = '0;
        fu_in_data_valid = '0;
        for (int i = 0; i < NUM_FU; i++) bcast_cnt[i] = 0;
        clear_bench();
        test_reset();
        test_single();
        test_fairness();
        test_full_boundary();
        test_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fu_wb_arbiter
`default_nettype wire
